// File: rtl/bin2bcd_ctrl.sv
// bin2bcd_ctrl: sequencer for a serial binary-to-BCD converter chain.
// Accepts a binary word on a start/busy/done handshake, streams it MSB-first
// into the chain (one bit per clock), then captures the packed BCD digits.
// While idle the converter is held cleared through conv_rst.
// Optional feature macro: BIN2BCD_CTRL_BLANK_EN adds the leading-zero blank
// flags output, registered together with bcd_out.
module bin2bcd_ctrl #(
   parameter int WIDTH  = 7,
   parameter int NDIGIT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      din,
   output logic                  busy,
   output logic                  done,
   output logic [NDIGIT*4-1:0]   bcd_out,
   output logic                  ovf,
   output logic                  conv_rst,
   output logic                  conv_bit,
   input  logic [NDIGIT*4-1:0]   conv_bcd
`ifdef BIN2BCD_CTRL_BLANK_EN
   ,
   output logic [NDIGIT-1:0]     blank
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   // Largest value representable in NDIGIT decimal digits, computed at elaboration.
   function automatic logic [63:0] max_bcd_value(input int ndig);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < ndig; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAX_BCD = max_bcd_value(NDIGIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] shreg_r;
   logic [CW-1:0]    cnt_r;
   logic             ovf_pend_r;
   logic             din_ovf_s;

   assign din_ovf_s = (64'(din) > MAX_BCD);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and converter drive, all derived from the state register.
   always_comb begin
      state_nxt_s = state_r;
      busy        = 1'b0;
      conv_rst    = 1'b1;
      conv_bit    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            conv_rst = 1'b0;
            conv_bit = shreg_r[WIDTH-1];
            if (cnt_r == LAST_CNT) begin
               state_nxt_s = CAPTURE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         CAPTURE: begin
            busy        = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Datapath: load on accept, shift while streaming, capture the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_r    <= '0;
         cnt_r      <= '0;
         ovf_pend_r <= 1'b0;
         bcd_out    <= '0;
         ovf        <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  shreg_r    <= din;
                  cnt_r      <= '0;
                  ovf_pend_r <= din_ovf_s;
               end
            end
            SHIFT: begin
               shreg_r <= shreg_r << 1;
               cnt_r   <= cnt_r + CW'(1);
            end
            CAPTURE: begin
               bcd_out <= conv_bcd;
               ovf     <= ovf_pend_r;
               done    <= 1'b1;
            end
            default: begin
               shreg_r <= '0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

`ifdef BIN2BCD_CTRL_BLANK_EN
   logic [NDIGIT-1:0] blank_s;
   logic              hi_zero_s;

   // Leading-zero flags: digit i blanks when it and every higher digit are zero.
   always_comb begin
      blank_s   = '0;
      hi_zero_s = 1'b1;
      for (int i = NDIGIT - 1; i >= 1; i--) begin
         hi_zero_s  = hi_zero_s & (conv_bcd[4*i +: 4] == 4'd0);
         blank_s[i] = hi_zero_s;
      end
   end

   // Blank flags are registered alongside bcd_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         blank <= '0;
      end else if (state_r == CAPTURE) begin
         blank <= blank_s;
      end else begin
         blank <= blank;
      end
   end
`endif

endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Self-checking bench for bin2bcd_ctrl (WIDTH=7, NDIGIT=2) with a behavioural
// serial double-dabble converter chain attached.
module tb_bin2bcd_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [6:0] din;
   logic       busy;
   logic       done;
   logic [7:0] bcd_out;
   logic       ovf;
   logic       conv_rst;
   logic       conv_bit;
   logic [7:0] conv_q;
`ifdef BIN2BCD_CTRL_BLANK_EN
   logic [1:0] blank;
`endif

   int tests_run;
   int tests_failed;

   bin2bcd_ctrl #(.WIDTH(7), .NDIGIT(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .din      (din),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .ovf      (ovf),
      .conv_rst (conv_rst),
      .conv_bit (conv_bit),
      .conv_bcd (conv_q)
`ifdef BIN2BCD_CTRL_BLANK_EN
      ,
      .blank    (blank)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Serial converter step: add 3 to each digit >= 5, then shift in the new bit.
   function automatic logic [7:0] dabble(input logic [7:0] q, input logic b);
      logic [7:0] a;
      a = q;
      for (int i = 0; i < 2; i++) begin
         if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return {a[6:0], b};
   endfunction

   // Converter chain registers; carry out of the top digit is dropped.
   always @(posedge clk) begin
      if (conv_rst) conv_q <= 8'h00;
      else          conv_q <= dabble(conv_q, conv_bit);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; din = 7'd0;
      repeat (3) tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         tests_run++;
         if (busy !== 1'b0 || done !== 1'b0 || conv_rst !== 1'b1 || conv_bit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl cyc%0d: busy=%b done=%b conv_rst=%b conv_bit=%b, want 0 0 1 0",
                     k, busy, done, conv_rst, conv_bit);
         end
         tests_run++;
         if (bcd_out !== 8'h00 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data cyc%0d: bcd_out=%h ovf=%b, want 00 0", k, bcd_out, ovf);
         end
      end
`ifdef BIN2BCD_CTRL_BLANK_EN
      tests_run++;
      if (blank !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_blank: blank=%b, want 00", blank);
      end
`endif
   endtask

   task automatic test_convert_99();
      din = 7'd99; start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (busy !== 1'b1 || conv_rst !== 1'b0 || conv_bit !== 1'b1) begin
         tests_failed++;
         $display("FAIL conv99_first_shift: busy=%b conv_rst=%b conv_bit=%b, want 1 0 1",
                  busy, conv_rst, conv_bit);
      end
      for (int k = 1; k < 8; k++) begin
         tick();
         tests_run++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL conv99_busy cyc%0d: busy=%b done=%b, want 1 0", k, busy, done);
         end
      end
      tick();
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0 || bcd_out !== 8'h99 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL conv99_result: done=%b busy=%b bcd_out=%h ovf=%b, want 1 0 99 0",
                  done, busy, bcd_out, ovf);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || bcd_out !== 8'h99) begin
         tests_failed++;
         $display("FAIL conv99_pulse: done=%b bcd_out=%h, want 0 99", done, bcd_out);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      din = 7'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      tests_run++;
      if (n !== 8 || bcd_out !== 8'h00 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_first: latency=%0d bcd_out=%h ovf=%b, want 8 00 0", n, bcd_out, ovf);
      end
      din = 7'd45; start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      tests_run++;
      if (n !== 9 || bcd_out !== 8'h45 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_second: spacing=%0d bcd_out=%h ovf=%b, want 9 45 0", n, bcd_out, ovf);
      end
   endtask

   task automatic test_overflow_ignore();
      int n;
      int extra;
      din = 7'd127; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      repeat (2) begin
         tick();
         n++;
      end
      din = 7'd5; start = 1'b1;
      tick();
      n++;
      start = 1'b0;
      while (done !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      tests_run++;
      if (n !== 8 || bcd_out !== 8'h27 || ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf127: latency=%0d bcd_out=%h ovf=%b, want 8 27 1", n, bcd_out, ovf);
      end
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b0) extra++;
      end
      tests_run++;
      if (extra !== 0 || bcd_out !== 8'h27) begin
         tests_failed++;
         $display("FAIL ignore_start: active_cycles=%0d bcd_out=%h, want 0 27", extra, bcd_out);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      int n;
      din = 7'd64; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 8'h00 || ovf !== 1'b0 || conv_rst !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid: busy=%b done=%b bcd_out=%h ovf=%b conv_rst=%b, want 0 0 00 0 1",
                  busy, done, bcd_out, ovf, conv_rst);
      end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      tests_run++;
      if (seen !== 0) begin
         tests_failed++;
         $display("FAIL rst_no_done: active_cycles=%0d, want 0", seen);
      end
      din = 7'd64; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      tests_run++;
      if (n !== 8 || bcd_out !== 8'h64 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_reconv: latency=%0d bcd_out=%h ovf=%b, want 8 64 0", n, bcd_out, ovf);
      end
   endtask

`ifdef BIN2BCD_CTRL_BLANK_EN
   task automatic test_blank();
      logic [6:0] vals [3];
      logic [1:0] exp_blank [3];
      logic [7:0] exp_bcd [3];
      int n;
      vals[0] = 7'd7;  exp_blank[0] = 2'b10; exp_bcd[0] = 8'h07;
      vals[1] = 7'd0;  exp_blank[1] = 2'b10; exp_bcd[1] = 8'h00;
      vals[2] = 7'd10; exp_blank[2] = 2'b00; exp_bcd[2] = 8'h10;
      for (int v = 0; v < 3; v++) begin
         din = vals[v]; start = 1'b1;
         tick();
         start = 1'b0;
         n = 0;
         while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
         end
         tests_run++;
         if (n !== 8 || blank !== exp_blank[v] || bcd_out !== exp_bcd[v]) begin
            tests_failed++;
            $display("FAIL blank din=%0d: latency=%0d blank=%b bcd_out=%h, want 8 %b %h",
                     vals[v], n, blank, bcd_out, exp_blank[v], exp_bcd[v]);
         end
         tick();
      end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst   = 1'b1;
      start = 1'b0;
      din   = 7'd0;
      test_reset();
      test_convert_99();
      test_back_to_back();
      test_overflow_ignore();
      test_reset_mid();
`ifdef BIN2BCD_CTRL_BLANK_EN
      test_blank();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
